// File: rtl/vid_mem_responder.sv
// vid_mem_responder: video-bus memory target serving read/write bursts from an internal word RAM
module vid_mem_responder #(
    parameter int DEPTH = 256,
    parameter int LAT = 3,
    parameter logic [3:0] MY_ID = 4'b0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        selin,
    input  logic [2:0]  cmdin,
    input  logic [1:0]  lenin,
    input  logic [3:0]  reqtarin,
    input  logic [3:0]  srcin,
    input  logic [31:0] addrdatain,
    input  logic        ackin,
    output logic [1:0]  reqout,
    output logic [2:0]  cmdout,
    output logic [1:0]  lenout,
    output logic [3:0]  reqtar,
    output logic [31:0] addrdataout,
    output logic        busy,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BID, RD_DATA, WR_DATA, WR_BID, WR_RESP} state_t;
    state_t state, state_nx;
    logic [31:0] ram [DEPTH];
    logic [AW-1:0] idx;
    logic [3:0] cnt, beats, src_q;
    logic [1:0] len_q;
    logic [31:0] addr_q;
    logic acc, rd_cmd, wr_cmd, dat_cmd, emit;
    assign acc = selin && reqtarin == MY_ID;
    assign rd_cmd = acc && cmdin == 3'b010;
    assign wr_cmd = acc && cmdin == 3'b100;
    assign dat_cmd = acc && cmdin == 3'b001;
    // beats holds the number of beats still to go after the current one
    assign emit = (state == RD_BID && ackin) || (state == RD_DATA && beats != 4'd0);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = rd_cmd ? RD_WAIT : wr_cmd ? WR_DATA : IDLE;
            RD_WAIT: state_nx = cnt <= 4'd1 ? RD_BID : RD_WAIT;
            RD_BID:  state_nx = ackin ? RD_DATA : RD_BID;
            RD_DATA: state_nx = beats == 4'd0 ? IDLE : RD_DATA;
            WR_DATA: state_nx = dat_cmd && beats == 4'd0 ? WR_BID : WR_DATA;
            WR_BID:  state_nx = ackin ? WR_RESP : WR_BID;
            default: state_nx = IDLE;
        endcase
        reqout = (state == RD_BID || state == WR_BID) ? 2'b11 : 2'b00;
        busy = state != IDLE;
    end
    always_ff @(posedge clk)
        if (state == WR_DATA && dat_cmd) ram[idx] <= addrdatain;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmdout <= '0;
            lenout <= '0;
            reqtar <= '0;
            addrdataout <= '0;
            err <= 1'b0;
            idx <= '0;
            cnt <= '0;
            beats <= '0;
            src_q <= '0;
            len_q <= '0;
            addr_q <= '0;
        end else begin
            if ((rd_cmd || wr_cmd) && state != IDLE) err <= 1'b1;
            if (state == IDLE && (rd_cmd || wr_cmd)) begin
                idx <= addrdatain[AW+1:2];
                addr_q <= addrdatain;
                len_q <= lenin;
                src_q <= srcin;
                cnt <= 4'(LAT);
                beats <= lenin == 2'b00 ? 4'd0 : lenin == 2'b01 ? 4'd3 : lenin == 2'b10 ? 4'd7 : 4'd15;
            end
            if (state == RD_WAIT) cnt <= cnt - 4'd1;
            if (state == RD_DATA || (state == WR_DATA && dat_cmd)) beats <= beats - 4'd1;
            if (emit || (state == WR_DATA && dat_cmd)) idx <= idx + 1'b1;
            if (emit) begin
                cmdout <= 3'b001;
                lenout <= len_q;
                reqtar <= src_q;
                addrdataout <= ram[idx];
            end else if (state == WR_BID && ackin) begin
                cmdout <= 3'b101;
                lenout <= len_q;
                reqtar <= src_q;
                addrdataout <= addr_q;
            end else if ((state == RD_DATA && beats == 4'd0) || state == WR_RESP) begin
                cmdout <= '0;
                lenout <= '0;
                reqtar <= '0;
                addrdataout <= '0;
            end
        end
    end
endmodule

// File: tb/tb_vid_mem_responder.sv
// tb_vid_mem_responder: directed self-checking bench for vid_mem_responder
module tb_vid_mem_responder;
    logic clk = 0, reset_n = 0, selin = 0, ackin = 0;
    logic [2:0] cmdin = 0;
    logic [1:0] lenin = 0;
    logic [3:0] reqtarin = 0, srcin = 0;
    logic [31:0] addrdatain = 0;
    logic [1:0] reqout, lenout;
    logic [2:0] cmdout;
    logic [3:0] reqtar;
    logic [31:0] addrdataout;
    logic busy, err;
    int checks = 0, errors = 0;
    logic [31:0] exp4 [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    vid_mem_responder dut (
        .clk(clk), .reset_n(reset_n), .selin(selin), .cmdin(cmdin), .lenin(lenin),
        .reqtarin(reqtarin), .srcin(srcin), .addrdatain(addrdatain), .ackin(ackin),
        .reqout(reqout), .cmdout(cmdout), .lenout(lenout), .reqtar(reqtar),
        .addrdataout(addrdataout), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic s, input logic [2:0] c, input logic [1:0] l, input logic [3:0] t,
                       input logic [3:0] src, input logic [31:0] d);
        selin = s; cmdin = c; lenin = l; reqtarin = t; srcin = src; addrdatain = d;
    endtask

    task automatic idle;
        bus(0, 3'b000, 2'b00, 4'h0, 4'h0, 32'h0);
    endtask

    // write burst of 1 or 4 beats, ack after dly bid cycles, then check the response
    task automatic wr(input logic [31:0] a, input logic [1:0] l, input logic [3:0] s, input int dly);
        bus(1, 3'b100, l, 4'h0, s, a);
        tick;
        chk("wr_busy", 32'(busy), 1);
        for (int i = 0; i < (l == 2'b00 ? 1 : 4); i++) begin
            bus(1, 3'b001, 2'b00, 4'h0, 4'h0, l == 2'b00 ? (a == 0 ? 32'h55 : 32'hAA) : exp4[i]);
            tick;
        end
        idle;
        for (int i = 0; i <= dly; i++) begin
            chk("wr_bid", 32'(reqout), 3);
            if (i < dly) tick;
        end
        ackin = 1;
        tick;
        ackin = 0;
        chk("wr_resp_cmd", 32'(cmdout), 5);
        chk("wr_resp_addr", addrdataout, a);
        chk("wr_resp_tar", 32'(reqtar), 32'(s));
        chk("wr_resp_len", 32'(lenout), 32'(l));
        chk("wr_resp_req", 32'(reqout), 0);
        tick;
        chk("wr_end_cmd", 32'(cmdout), 0);
        chk("wr_end_busy", 32'(busy), 0);
    endtask

    // read address phase, fixed-latency bid check, ack; returns in the beat-0 cycle
    task automatic rd(input logic [31:0] a, input logic [1:0] l, input logic [3:0] s, input logic intrude);
        bus(1, 3'b010, l, 4'h0, s, a);
        tick;
        for (int i = 0; i < 3; i++) begin
            if (intrude && i == 0) bus(1, 3'b010, 2'b00, 4'h5, 4'h1, 32'h0);
            else idle;
            chk("rd_wait_req", 32'(reqout), 0);
            tick;
        end
        idle;
        chk("rd_bid", 32'(reqout), 3);
        ackin = 1;
        tick;
        ackin = 0;
        chk("rd_req_drop", 32'(reqout), 0);
    endtask

    initial begin
        #12;
        chk("rst_cmd", 32'(cmdout), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_req", 32'(reqout), 0);
        tick;
        reset_n = 1;
        tick;
        // foreign target id is never accepted
        bus(1, 3'b100, 2'b01, 4'h5, 4'h2, 32'h10);
        tick;
        idle;
        chk("foreign_busy", 32'(busy), 0);
        wr(32'h10, 2'b01, 4'h2, 2);
        rd(32'h10, 2'b01, 4'h3, 1);
        for (int i = 0; i < 4; i++) begin
            chk("rd_cmd", 32'(cmdout), 1);
            chk("rd_data", addrdataout, exp4[i]);
            chk("rd_len", 32'(lenout), 1);
            chk("rd_tar", 32'(reqtar), 3);
            tick;
        end
        chk("rd_end_cmd", 32'(cmdout), 0);
        chk("rd_end_data", addrdataout, 0);
        chk("rd_end_busy", 32'(busy), 0);
        chk("foreign_err", 32'(err), 0);
        // wrap across the top of the RAM, read issued back-to-back after the write
        wr(32'h0, 2'b00, 4'h7, 0);
        wr(32'h3FC, 2'b00, 4'h7, 0);
        rd(32'h3FC, 2'b10, 4'h8, 0);
        chk("wrap_b0", addrdataout, 32'hAA);
        tick;
        chk("wrap_b1", addrdataout, 32'h55);
        for (int i = 0; i < 7; i++) tick;
        chk("wrap_end_cmd", 32'(cmdout), 0);
        chk("wrap_end_busy", 32'(busy), 0);
        // read address dropped mid-burst sets err, burst unaffected
        rd(32'h10, 2'b01, 4'h3, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) bus(1, 3'b010, 2'b00, 4'h0, 4'h9, 32'h0);
            else idle;
            chk("drop_data", addrdataout, exp4[i]);
            chk("drop_cmd", 32'(cmdout), 1);
            tick;
        end
        chk("drop_err", 32'(err), 1);
        chk("drop_end_cmd", 32'(cmdout), 0);
        tick;
        chk("drop_no_start", 32'(busy), 0);
        // async reset during beat 2 of a 16-beat read
        rd(32'h10, 2'b11, 4'h4, 0);
        tick;
        tick;
        chk("rst16_b2", addrdataout, 32'h33);
        #1 reset_n = 0;
        #1;
        chk("arst_cmd", 32'(cmdout), 0);
        chk("arst_data", addrdataout, 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_tar", 32'(reqtar), 0);
        tick;
        tick;
        reset_n = 1;
        tick;
        chk("post_rst_cmd", 32'(cmdout), 0);
        rd(32'h14, 2'b00, 4'h6, 0);
        chk("single_cmd", 32'(cmdout), 1);
        chk("single_data", addrdataout, 32'h22);
        chk("single_tar", 32'(reqtar), 6);
        chk("single_len", 32'(lenout), 0);
        tick;
        chk("single_end_cmd", 32'(cmdout), 0);
        chk("single_end_busy", 32'(busy), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
